// File: rtl/alarm_controller.sv
// Alarm clock controller: stores a validated HH:MM alarm, rings on the rising
// edge of a time match, supports snooze/stop and drives a rotating LED pattern.
module alarm_controller #(
  parameter int unsigned RING_TIMEOUT_S = 60,
  parameter int unsigned SNOOZE_S       = 300
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick,
  input  logic [23:0] time_now,
  input  logic        alarm_enable,
  input  logic        alarm_set,
  input  logic [15:0] alarm_time_in,
  input  logic        snooze,
  input  logic        stop,
  output logic [15:0] alarm_time,
  output logic        armed,
  output logic        ringing,
  output logic [15:0] led
);

  localparam int unsigned MaxCnt = (RING_TIMEOUT_S > SNOOZE_S) ? RING_TIMEOUT_S : SNOOZE_S;
  localparam int unsigned CntW   = (MaxCnt < 1) ? 1 : $clog2(MaxCnt + 1);
  localparam logic [CntW-1:0] RingMax   = CntW'(RING_TIMEOUT_S);
  localparam logic [CntW-1:0] SnoozeMax = CntW'(SNOOZE_S);

  typedef enum logic [1:0] {StDisabled, StArmed, StRinging, StSnooze} state_e;

  state_e            state_q, state_d;
  logic [15:0]       alarm_time_d;
  logic [CntW-1:0]   ring_cnt_q, ring_cnt_d;
  logic [CntW-1:0]   snooze_cnt_q, snooze_cnt_d;
  logic [15:0]       led_d;
  logic              armed_d, ringing_d;
  logic              match, match_q;
  logic              set_valid;

  assign set_valid = alarm_set && (alarm_time_in[15:8] <= 8'd23) && (alarm_time_in[7:0] <= 8'd59);
  assign match     = (time_now == {alarm_time, 8'd0});

  // Next-state, counters and output pattern; ticks only count in the state
  // held since the previous cycle, so a tick on an entry cycle is dropped.
  always_comb begin
    state_d      = state_q;
    alarm_time_d = set_valid ? alarm_time_in : alarm_time;
    ring_cnt_d   = ring_cnt_q;
    snooze_cnt_d = snooze_cnt_q;
    led_d        = led;

    if (!alarm_enable) begin
      state_d = StDisabled;
    end else begin
      unique case (state_q)
        StDisabled: state_d = StArmed;
        StArmed: begin
          // Rising edge only: a held match must not re-trigger after stop/timeout.
          if (match && !match_q) begin
            state_d    = StRinging;
            ring_cnt_d = '0;
            led_d      = 16'h0001;
          end
        end
        StRinging: begin
          if (stop) begin
            state_d = StArmed;
          end else if (snooze) begin
            state_d      = StSnooze;
            snooze_cnt_d = '0;
          end else if (set_valid) begin
            state_d = StArmed;
          end else if (tick) begin
            ring_cnt_d = ring_cnt_q + 1'b1;
            led_d      = {led[14:0], led[15]};
            if (ring_cnt_d == RingMax) state_d = StArmed;
          end
        end
        StSnooze: begin
          if (stop || set_valid) begin
            state_d = StArmed;
          end else if (tick) begin
            snooze_cnt_d = snooze_cnt_q + 1'b1;
            if (snooze_cnt_d == SnoozeMax) begin
              state_d    = StRinging;
              ring_cnt_d = '0;
              led_d      = 16'h0001;
            end
          end
        end
        default: state_d = StDisabled;
      endcase
    end

    // LEDs are dark in every state except RINGING.
    if (state_d != StRinging) led_d = '0;
    armed_d   = (state_d != StDisabled);
    ringing_d = (state_d == StRinging);
  end

  // State and registered outputs; reset overrides every input.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StDisabled;
      alarm_time   <= 16'h0700;
      ring_cnt_q   <= '0;
      snooze_cnt_q <= '0;
      match_q      <= 1'b0;
      led          <= '0;
      armed        <= 1'b0;
      ringing      <= 1'b0;
    end else begin
      state_q      <= state_d;
      alarm_time   <= alarm_time_d;
      ring_cnt_q   <= ring_cnt_d;
      snooze_cnt_q <= snooze_cnt_d;
      match_q      <= match;
      led          <= led_d;
      armed        <= armed_d;
      ringing      <= ringing_d;
    end
  end

endmodule
